// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller: states, opcodes,
// ALUOp classes and ALU operation codes.
package multicycle_controller_pkg;

    localparam int unsigned STATE_W   = 4;
    localparam int unsigned OP_W      = 7;
    localparam int unsigned FUNCT3_W  = 3;
    localparam int unsigned ALUOP_W   = 2;
    localparam int unsigned ALUCTRL_W = 3;
    localparam int unsigned SEL_W     = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [ALUCTRL_W-1:0] ALUC_ADD = 3'b000;
    localparam logic [ALUCTRL_W-1:0] ALUC_SUB = 3'b001;
    localparam logic [ALUCTRL_W-1:0] ALUC_AND = 3'b010;
    localparam logic [ALUCTRL_W-1:0] ALUC_XOR = 3'b011;
    localparam logic [ALUCTRL_W-1:0] ALUC_SLT = 3'b101;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the controller's ALUOp class plus instruction fields onto an ALU operation.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [ALUOP_W-1:0]   alu_op,
    input  logic [FUNCT3_W-1:0]  funct3,
    input  logic                 op5,
    input  logic                 funct7b5,
    output logic [ALUCTRL_W-1:0] alu_control
);

    always_comb begin
        alu_control = ALUC_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALUC_ADD;
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // sub only for R-type with funct7[5]; addi ignores bit 30
                    3'b000:  alu_control = (op5 & funct7b5) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  alu_control = ALUC_SLT;
                    3'b100:  alu_control = ALUC_XOR;
                    3'b111:  alu_control = ALUC_AND;
                    default: alu_control = ALUC_ADD;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: Moore state decode with memory handshake waits,
// branch-qualified PC write and an illegal-opcode pulse in DECODE.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OP_W-1:0]      op,
    input  logic [FUNCT3_W-1:0]  funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic [SEL_W-1:0]     ResultSrc,
    output logic [SEL_W-1:0]     ALUSrcA,
    output logic [SEL_W-1:0]     ALUSrcB,
    output logic [SEL_W-1:0]     ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 illegal,
    output logic [STATE_W-1:0]   state
);

    state_t             state_q, state_d;
    logic               pc_update, branch, ir_write, reg_write, mem_write;
    logic [ALUOP_W-1:0] alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = ALUOP_ADD;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_update = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Write enables are forced low while reset is held, even though FETCH is active.
    assign PCWrite  = rst_n & (pc_update | (branch & zero));
    assign IRWrite  = rst_n & ir_write;
    assign RegWrite = rst_n & reg_write;
    assign MemWrite = rst_n & mem_write;
    assign state    = state_q;

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed cycle-by-cycle bench for multicycle_controller with a scoreboard of
// expected per-cycle outputs.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    logic       clk, rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    typedef struct {
        logic [3:0] st;
        logic       pcw, irw, rw, mw, ill;
        logic [2:0] alu;
        logic [1:0] rsrc, imm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] cur_op     = 7'b0;
    logic [2:0] cur_funct3 = 3'b0;
    logic       cur_f7     = 1'b0;
    logic [1:0] cur_imm    = 2'b0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // New instruction fields take effect at the next step's negedge.
    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic [1:0] imm);
        cur_op = o; cur_funct3 = f3; cur_f7 = f7; cur_imm = imm;
    endtask

    task automatic step(input logic rst, input logic rdy, input logic z, input state_t st,
                        input logic pcw, input logic irw, input logic rw, input logic mw,
                        input logic ill, input logic [2:0] alu, input logic [1:0] rsrc);
        exp_t e, g;
        @(negedge clk);
        rst_n = rst; mem_ready = rdy; zero = z;
        op = cur_op; funct3 = cur_funct3; funct7b5 = cur_f7;
        e.st = st; e.pcw = pcw; e.irw = irw; e.rw = rw; e.mw = mw; e.ill = ill;
        e.alu = alu; e.rsrc = rsrc; e.imm = cur_imm;
        exp_q.push_back(e);
        #1;
        g = exp_q.pop_front();
        chk("state", state, g.st);
        chk("PCWrite", {3'b0, PCWrite}, {3'b0, g.pcw});
        chk("IRWrite", {3'b0, IRWrite}, {3'b0, g.irw});
        chk("RegWrite", {3'b0, RegWrite}, {3'b0, g.rw});
        chk("MemWrite", {3'b0, MemWrite}, {3'b0, g.mw});
        chk("illegal", {3'b0, illegal}, {3'b0, g.ill});
        chk("ALUControl", {1'b0, ALUControl}, {1'b0, g.alu});
        chk("ResultSrc", {2'b0, ResultSrc}, {2'b0, g.rsrc});
        chk("ImmSrc", {2'b0, ImmSrc}, {2'b0, g.imm});
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0;
        op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0;

        // reset held with mem_ready=1: FETCH but no write enables
        set_instr(OP_LW, 3'b010, 1'b0, 2'b00);
        step(0, 1, 0, S_FETCH,   0, 0, 0, 0, 0, 3'b000, 2'b10);
        // lw: 5 cycles
        step(1, 1, 0, S_FETCH,   1, 1, 0, 0, 0, 3'b000, 2'b10);
        step(1, 1, 0, S_DECODE,  0, 0, 0, 0, 0, 3'b000, 2'b00);
        step(1, 1, 0, S_MEMADR,  0, 0, 0, 0, 0, 3'b000, 2'b00);
        step(1, 1, 0, S_MEMREAD, 0, 0, 0, 0, 0, 3'b000, 2'b00);
        step(1, 1, 0, S_MEMWB,   0, 0, 1, 0, 0, 3'b000, 2'b01);

        // R-type: sub, slt, xor
        set_instr(OP_R, 3'b000, 1'b1, 2'b00);
        step(1, 1, 0, S_FETCH,    1, 1, 0, 0, 0, 3'b000, 2'b10);
        step(1, 1, 0, S_DECODE,   0, 0, 0, 0, 0, 3'b000, 2'b00);
        step(1, 1, 0, S_EXECUTER, 0, 0, 0, 0, 0, 3'b001, 2'b00);
        step(1, 1, 0, S_ALUWB,    0, 0, 1, 0, 0, 3'b000, 2'b00);
        set_instr(OP_R, 3'b010, 1'b0, 2'b00);
        step(1, 1, 0, S_FETCH,    1, 1, 0, 0, 0, 3'b000, 2'b10);
        step(1, 1, 0, S_DECODE,   0, 0, 0, 0, 0, 3'b000, 2'b00);
        step(1, 1, 0, S_EXECUTER, 0, 0, 0, 0, 0, 3'b101, 2'b00);
        step(1, 1, 0, S_ALUWB,    0, 0, 1, 0, 0, 3'b000, 2'b00);
        set_instr(OP_R, 3'b100, 1'b0, 2'b00);
        step(1, 1, 0, S_FETCH,    1, 1, 0, 0, 0, 3'b000, 2'b10);
        step(1, 1, 0, S_DECODE,   0, 0, 0, 0, 0, 3'b000, 2'b00);
        step(1, 1, 0, S_EXECUTER, 0, 0, 0, 0, 0, 3'b011, 2'b00);
        step(1, 1, 0, S_ALUWB,    0, 0, 1, 0, 0, 3'b000, 2'b00);

        // I-type: bit 30 set but addi must stay add; andi
        set_instr(OP_I, 3'b000, 1'b1, 2'b00);
        step(1, 1, 0, S_FETCH,    1, 1, 0, 0, 0, 3'b000, 2'b10);
        step(1, 1, 0, S_DECODE,   0, 0, 0, 0, 0, 3'b000, 2'b00);
        step(1, 1, 0, S_EXECUTEI, 0, 0, 0, 0, 0, 3'b000, 2'b00);
        step(1, 1, 0, S_ALUWB,    0, 0, 1, 0, 0, 3'b000, 2'b00);
        set_instr(OP_I, 3'b111, 1'b0, 2'b00);
        step(1, 1, 0, S_FETCH,    1, 1, 0, 0, 0, 3'b000, 2'b10);
        step(1, 1, 0, S_DECODE,   0, 0, 0, 0, 0, 3'b000, 2'b00);
        step(1, 1, 0, S_EXECUTEI, 0, 0, 0, 0, 0, 3'b010, 2'b00);
        step(1, 1, 0, S_ALUWB,    0, 0, 1, 0, 0, 3'b000, 2'b00);

        // sw with fetch stall and three memory wait cycles
        set_instr(OP_SW, 3'b010, 1'b0, 2'b01);
        step(1, 0, 0, S_FETCH,    0, 0, 0, 0, 0, 3'b000, 2'b10);
        step(1, 1, 0, S_FETCH,    1, 1, 0, 0, 0, 3'b000, 2'b10);
        step(1, 1, 0, S_DECODE,   0, 0, 0, 0, 0, 3'b000, 2'b00);
        step(1, 1, 0, S_MEMADR,   0, 0, 0, 0, 0, 3'b000, 2'b00);
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, S_MEMWRITE, 0, 0, 0, 1, 0, 3'b000, 2'b00);
        step(1, 1, 0, S_MEMWRITE, 0, 0, 0, 1, 0, 3'b000, 2'b00);

        // beq taken then not taken
        set_instr(OP_BEQ, 3'b000, 1'b0, 2'b10);
        step(1, 1, 1, S_FETCH,  1, 1, 0, 0, 0, 3'b000, 2'b10);
        step(1, 1, 1, S_DECODE, 0, 0, 0, 0, 0, 3'b000, 2'b00);
        step(1, 1, 1, S_BEQ,    1, 0, 0, 0, 0, 3'b001, 2'b00);
        step(1, 1, 0, S_FETCH,  1, 1, 0, 0, 0, 3'b000, 2'b10);
        step(1, 1, 0, S_DECODE, 0, 0, 0, 0, 0, 3'b000, 2'b00);
        step(1, 1, 0, S_BEQ,    0, 0, 0, 0, 0, 3'b001, 2'b00);

        // jal
        set_instr(OP_JAL, 3'b000, 1'b0, 2'b11);
        step(1, 1, 0, S_FETCH,  1, 1, 0, 0, 0, 3'b000, 2'b10);
        step(1, 1, 0, S_DECODE, 0, 0, 0, 0, 0, 3'b000, 2'b00);
        step(1, 1, 0, S_JAL,    1, 0, 0, 0, 0, 3'b000, 2'b00);
        step(1, 1, 0, S_ALUWB,  0, 0, 1, 0, 0, 3'b000, 2'b00);

        // unsupported opcode: illegal pulse, back to FETCH
        set_instr(7'b1111111, 3'b000, 1'b0, 2'b00);
        step(1, 1, 0, S_FETCH,  1, 1, 0, 0, 0, 3'b000, 2'b10);
        step(1, 1, 0, S_DECODE, 0, 0, 0, 0, 1, 3'b000, 2'b00);

        // lw aborted by reset while waiting in MEMREAD
        set_instr(OP_LW, 3'b010, 1'b0, 2'b00);
        step(1, 1, 0, S_FETCH,   1, 1, 0, 0, 0, 3'b000, 2'b10);
        step(1, 1, 0, S_DECODE,  0, 0, 0, 0, 0, 3'b000, 2'b00);
        step(1, 1, 0, S_MEMADR,  0, 0, 0, 0, 0, 3'b000, 2'b00);
        step(1, 0, 0, S_MEMREAD, 0, 0, 0, 0, 0, 3'b000, 2'b00);
        step(0, 1, 0, S_FETCH,   0, 0, 0, 0, 0, 3'b000, 2'b10);
        step(1, 0, 0, S_FETCH,   0, 0, 0, 0, 0, 3'b000, 2'b10);
        step(1, 0, 0, S_FETCH,   0, 0, 0, 0, 0, 3'b000, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, on the ports `clk` and `rst_n`.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 op  input  7  instruction opcode field, bits [6:0].
REQ-005 funct3  input  3  instruction bits [14:12].
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 zero  input  1  ALU result-equals-zero flag.
REQ-008 mem_ready  input  1  memory handshake; the current memory access completes in any cycle where it is 1.
REQ-009 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  output  1 each  datapath enables and selects.
REQ-010 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath mux selects.
REQ-011 ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 xor, 101 slt.
REQ-012 illegal  output  1  one-cycle pulse in DECODE when the opcode is unsupported.
REQ-013 state  output  4  current FSM state, for debug.

Function
REQ-014 Opcodes SHALL be decoded as: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
REQ-015 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ and JAL; the next state registers on each rising edge of clk.
REQ-016 Transitions SHALL be:
- FETCH->DECODE only when mem_ready=1; otherwise FETCH holds.
- DECODE: lw or sw ->MEMADR; R ->EXECUTER; I-ALU ->EXECUTEI; beq ->BEQ; jal ->JAL; any other opcode ->FETCH.
- MEMADR: lw ->MEMREAD; sw ->MEMWRITE.
- MEMREAD->MEMWB, and MEMWRITE->FETCH, each only when mem_ready=1; otherwise the state holds.
- MEMWB->FETCH; EXECUTER->ALUWB; EXECUTEI->ALUWB; JAL->ALUWB; ALUWB->FETCH; BEQ->FETCH.
REQ-017 Outputs SHALL be Moore, decoded from state; any output not listed for a state is 0.
- FETCH: ALUSrcB=10, ResultSrc=10, ALUOp=00. IRWrite=1 and PC update=1 only in the cycle where mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1, held until mem_ready=1.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PC update=1.
REQ-018 PCWrite SHALL equal PC update OR (Branch AND zero).
REQ-019 ALUControl SHALL be derived from ALUOp as follows:
- ALUOp 00 -> 000.
- ALUOp 01 -> 001.
- ALUOp 10 with funct3 000 -> 001 if (op[5] AND funct7b5), else 000.
- ALUOp 10 with funct3 010 -> 101; 100 -> 011; 111 -> 010; any other funct3 -> 000.
REQ-020 ImmSrc SHALL be a combinational decode of op: sw 01, beq 10, jal 11, all other opcodes 00.
REQ-021 illegal SHALL be 1 only in DECODE with an unsupported opcode; no write enable is asserted on that path.
REQ-022 The latency in cycles from FETCH to the next FETCH, with mem_ready held at 1, SHALL be: lw 5, sw 4, R 4, I 4, jal 4, beq 3.

Reset
REQ-023 While rst_n=0, state SHALL be FETCH immediately and asynchronously.
REQ-024 A reset asserted in any state, including mid-wait on mem_ready, SHALL abort the instruction with no further write enables.
REQ-025 With rst_n=0, all write enables SHALL be 0: PCWrite, IRWrite, RegWrite and MemWrite.

Structure
REQ-026 A shared package SHALL hold the state encoding, the opcode constants, the ALUOp constants and the ALUControl constants (000, 001, 010, 011, 101).
REQ-027 The ALUOp-to-ALUControl mapping SHALL be a separate combinational sub-module named alu_decoder.
REQ-028 The state register, next-state logic and output decode SHALL live in multicycle_controller.

Verification
REQ-029 Release rst_n with mem_ready=1 and op=0000011 (lw) -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB,FETCH; RegWrite=1 only in MEMWB; ResultSrc=01.
REQ-030 Apply op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER; with funct3=010 -> 101; with funct3=100 -> 011.
REQ-031 Apply op=0100011 (sw) with mem_ready=0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, then FETCH.
REQ-032 Apply op=1100011 (beq) in BEQ with zero=1 -> PCWrite=1 and ALUControl=001; with zero=0 -> PCWrite=0.
REQ-033 Apply op=1111111 -> illegal=1 for one cycle in DECODE, no write enable, next state FETCH.
REQ-034 Assert rst_n=0 mid-MEMREAD -> state=FETCH immediately; no RegWrite follows.
